// File: rtl/cc_matrix_scan.sv
// Purpose : time-multiplexed 8x8 LED matrix scanner with per-row blanking gap
//           and an optional shadow frame buffer (macro CC_MATRIX_SCAN_SHADOW_EN).
// Latency : all outputs registered; they change on the same edge as the state.
// Backpressure: none; free-running scan gated only by Enable_In.
//
// Ports:
//   CC_MATRIX_SCAN_CLOCK_50       in   1  system clock (rising edge)
//   CC_MATRIX_SCAN_RESET_InLow    in   1  asynchronous active-low reset
//   CC_MATRIX_SCAN_Enable_In      in   1  1 = scan, 0 = dark, position held at row 0
//   CC_MATRIX_SCAN_D0..D7_InBus   in   8  row patterns, bit i = column i, 0 = lit
//   CC_MATRIX_SCAN_Row_OutBus     out  8  one-hot active-high row select
//   CC_MATRIX_SCAN_Col_OutBus     out  8  active-low column drive
//   CC_MATRIX_SCAN_FrameDone_Out  out  1  one-cycle pulse at each frame boundary
//
// Config: define CC_MATRIX_SCAN_SHADOW_EN to latch the frame at scan start and at
// every frame wrap; otherwise Col follows the live input of the shown row.
module cc_matrix_scan #(
  parameter int ROW_CYCLES   = 5000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic       CC_MATRIX_SCAN_CLOCK_50,
  input  logic       CC_MATRIX_SCAN_RESET_InLow,
  input  logic       CC_MATRIX_SCAN_Enable_In,
  input  logic [7:0] CC_MATRIX_SCAN_D0_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D1_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D2_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D3_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D4_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D5_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D6_InBus,
  input  logic [7:0] CC_MATRIX_SCAN_D7_InBus,
  output logic [7:0] CC_MATRIX_SCAN_Row_OutBus,
  output logic [7:0] CC_MATRIX_SCAN_Col_OutBus,
  output logic       CC_MATRIX_SCAN_FrameDone_Out
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  // With no blanking gap every row slot starts directly in SHOW.
  localparam logic [1:0] SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  logic [1:0]    r_state;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_row;
  logic [7:0]    r_col;
  logic          r_frame_done;

  logic [1:0]    w_state_nxt;
  logic [2:0]    w_idx_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_reload;
  logic          w_frame;
  logic [7:0]    w_col_src;
  logic [7:0]    w_d [8];

  assign w_d[0] = CC_MATRIX_SCAN_D0_InBus;
  assign w_d[1] = CC_MATRIX_SCAN_D1_InBus;
  assign w_d[2] = CC_MATRIX_SCAN_D2_InBus;
  assign w_d[3] = CC_MATRIX_SCAN_D3_InBus;
  assign w_d[4] = CC_MATRIX_SCAN_D4_InBus;
  assign w_d[5] = CC_MATRIX_SCAN_D5_InBus;
  assign w_d[6] = CC_MATRIX_SCAN_D6_InBus;
  assign w_d[7] = CC_MATRIX_SCAN_D7_InBus;

  assign w_cnt_inc = r_cnt + CW'(1);

  // cnt runs 0..ROW_CYCLES-1 across one whole row slot; the BLANK->SHOW
  // switch happens when it reaches BLANK_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_reload    = 1'b0;
    w_frame     = 1'b0;
    if (!CC_MATRIX_SCAN_Enable_In) begin
      // Disable overrides everything, including a coincident frame wrap.
      w_state_nxt = IDLE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_reload    = 1'b1;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = SLOT_START;
        end
        BLANK, SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = SLOT_START;
            if (r_idx == 3'd7) begin
              w_frame  = 1'b1;
              w_reload = 1'b1;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (r_state == BLANK && w_cnt_inc == CNT_SHOW) begin
              w_state_nxt = SHOW;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef CC_MATRIX_SCAN_SHADOW_EN
  logic [7:0] r_s [8];

  // On a reload edge the row being entered must already show the new frame,
  // so bypass the shadow and take the live input.
  assign w_col_src = w_reload ? w_d[w_idx_nxt] : r_s[w_idx_nxt];

  always_ff @(posedge CC_MATRIX_SCAN_CLOCK_50 or negedge CC_MATRIX_SCAN_RESET_InLow) begin
    if (!CC_MATRIX_SCAN_RESET_InLow) begin
      for (int i = 0; i < 8; i++) r_s[i] <= 8'hFF;
    end else if (w_reload) begin
      for (int i = 0; i < 8; i++) r_s[i] <= w_d[i];
    end
  end
`else
  assign w_col_src = w_d[w_idx_nxt];
`endif

  always_ff @(posedge CC_MATRIX_SCAN_CLOCK_50 or negedge CC_MATRIX_SCAN_RESET_InLow) begin
    if (!CC_MATRIX_SCAN_RESET_InLow) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= '0;
      r_row        <= 8'h00;
      r_col        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_frame;
      // Outputs are decoded from the next state so they move with it.
      if (w_state_nxt == SHOW) begin
        r_row <= 8'd1 << w_idx_nxt;
        r_col <= w_col_src;
      end else begin
        r_row <= 8'h00;
        r_col <= 8'hFF;
      end
    end
  end

  assign CC_MATRIX_SCAN_Row_OutBus    = r_row;
  assign CC_MATRIX_SCAN_Col_OutBus    = r_col;
  assign CC_MATRIX_SCAN_FrameDone_Out = r_frame_done;

endmodule
